// File: rtl/io_pkg.sv
// io_pkg: definitions shared by the dma_io peripherals (io_timer, io_led).
//  - IO_WIN_WORDS: size of the word window each peripheral decodes.
//  - TMR_*: io_timer register offsets from its base word address.
//  - CTRL_*: bit positions inside the io_timer CTRL register.
//  - io_chain_rdata: the read-data daisy-chain convention. A device drives its
//    own registered read data when it owns the address, otherwise it passes
//    the upstream device's data through combinationally.
package io_pkg;

  localparam int unsigned IO_WIN_WORDS = 8;

  localparam logic [2:0] TMR_CTRL = 3'd0;
  localparam logic [2:0] TMR_PS   = 3'd1;
  localparam logic [2:0] TMR_CNT  = 3'd2;
  localparam logic [2:0] TMR_CMP  = 3'd3;
  localparam logic [2:0] TMR_STAT = 3'd4;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  function automatic logic [31:0] io_chain_rdata(input logic        hit,
                                                 input logic [31:0] own_data,
                                                 input logic [31:0] rdata_in);
    return hit ? own_data : rdata_in;
  endfunction

endpackage

// File: rtl/io_prescaler.sv
// io_prescaler: divides the clock down to a single-cycle tick.
//  clk, rst_n : clock, synchronous active-low reset
//  en         : counting enable; while low the counter is held at zero
//  clr        : restart the division from zero (register reprogramming)
//  limit      : tick every limit+1 enabled cycles (limit=0 ticks every cycle)
//  tick       : one-cycle pulse when the counter reaches limit
module io_prescaler #(
  parameter int PS_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic [PS_WIDTH-1:0] limit,
  output logic                tick
);

  localparam logic [PS_WIDTH-1:0] PS_ONE = 1;

  logic [PS_WIDTH-1:0] ps_cnt_q;
  logic [PS_WIDTH-1:0] ps_cnt_d;

  // The tick still fires on a cycle that also clears: the clear only restarts
  // the division for the following cycles.
  assign tick = en && (ps_cnt_q == limit);

  always_comb begin
    ps_cnt_d = ps_cnt_q + PS_ONE;
    if (!en || clr || tick) begin
      ps_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt_q <= '0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
    end
  end

endmodule

// File: rtl/io_timer.sv
// io_timer: memory-mapped 32-bit timer/compare peripheral on the dma_io bus.
// Registers (word offsets from IO_BASE):
//   +0 CTRL     [0]=en [1]=autoreload [2]=ie
//   +1 PRESCALE [PS_WIDTH-1:0]
//   +2 COUNT    32-bit up counter, advances once per prescaler tick
//   +3 COMPARE  32-bit match value
//   +4 STATUS   [0]=pending, write 1 to clear
//   +5..+7      reserved, read 0, writes ignored
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   dma_io_we        single-cycle write strobe with dma_io_wadr/dma_io_wdata
//   dma_io_radr      read word address; data appears one cycle later
//   dma_io_rdata_in  read data from the upstream device in the chain
//   dma_io_rdata     chained read data to the downstream device / CPU
//   timer_irq        level interrupt = pending & ie
// Bus semantics: the dma_io bus has no handshake. A write is accepted at the
// posedge where dma_io_we is high; a read always completes with fixed
// one-cycle latency and never stalls.
module io_timer
  import io_pkg::*;
#(
  parameter logic [13:0] IO_BASE  = 14'h0100,
  parameter int          PS_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        timer_irq
);

  // ---------------------------------------------------------------------------
  // Address decode. Offsets are taken relative to IO_BASE so the window need
  // not be aligned; the unsigned wrap makes addresses below the base miss.
  // ---------------------------------------------------------------------------
  logic [13:0] woff;
  logic [13:0] roff;
  logic        w_hit;
  logic        r_hit;
  logic        wr_ctrl;
  logic        wr_ps;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_stat;

  assign woff  = dma_io_wadr - IO_BASE;
  assign roff  = dma_io_radr - IO_BASE;
  assign w_hit = dma_io_we && (woff < 14'(IO_WIN_WORDS));
  assign r_hit = (roff < 14'(IO_WIN_WORDS));

  assign wr_ctrl = w_hit && (woff[2:0] == TMR_CTRL);
  assign wr_ps   = w_hit && (woff[2:0] == TMR_PS);
  assign wr_cnt  = w_hit && (woff[2:0] == TMR_CNT);
  assign wr_cmp  = w_hit && (woff[2:0] == TMR_CMP);
  assign wr_stat = w_hit && (woff[2:0] == TMR_STAT);

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [2:0]          ctrl_q,   ctrl_d;
  logic [PS_WIDTH-1:0] ps_q,     ps_d;
  logic [31:0]         count_q,  count_d;
  logic [31:0]         cmp_q,    cmp_d;
  logic                pend_q,   pend_d;
  logic                rd_hit_q, rd_hit_d;
  logic [31:0]         rd_reg_q, rd_reg_d;

  // ---------------------------------------------------------------------------
  // Prescaler. Reprogramming CTRL or PRESCALE restarts the division so the
  // first tick after a write is a full period away.
  // ---------------------------------------------------------------------------
  logic tick;

  io_prescaler #(
    .PS_WIDTH(PS_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ctrl_q[CTRL_EN]),
    .clr  (wr_ctrl || wr_ps),
    .limit(ps_q),
    .tick (tick)
  );

  // Match is evaluated against the current COUNT/COMPARE, so a COMPARE write
  // only influences the next cycle's test.
  logic match;
  assign match = tick && (count_q == cmp_q);

  // ---------------------------------------------------------------------------
  // Next-state logic for the register file and counter
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d  = ctrl_q;
    ps_d    = ps_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    pend_d  = pend_q;

    if (wr_ctrl) begin
      ctrl_d = dma_io_wdata[2:0];
    end
    if (wr_ps) begin
      ps_d = dma_io_wdata[PS_WIDTH-1:0];
    end
    if (wr_cmp) begin
      cmp_d = dma_io_wdata;
    end

    // COUNT wraps naturally from all-ones to zero.
    if (tick) begin
      if (match && ctrl_q[CTRL_AR]) begin
        count_d = '0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
    // A firmware write overrides whatever the tick would have done.
    if (wr_cnt) begin
      count_d = dma_io_wdata;
    end

    // Set is ordered after clear so a same-cycle match is never lost.
    if (wr_stat && dma_io_wdata[0]) begin
      pend_d = 1'b0;
    end
    if (match) begin
      pend_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: capture hit and data at the address cycle, mux one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_hit_d = r_hit;
    rd_reg_d = '0;
    if (r_hit) begin
      case (roff[2:0])
        TMR_CTRL: rd_reg_d = {29'd0, ctrl_q};
        TMR_PS:   rd_reg_d = 32'(ps_q);
        TMR_CNT:  rd_reg_d = count_q;
        TMR_CMP:  rd_reg_d = cmp_q;
        TMR_STAT: rd_reg_d = {31'd0, pend_q};
        default:  rd_reg_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      ps_q     <= '0;
      count_q  <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      pend_q   <= 1'b0;
      rd_hit_q <= 1'b0;
      rd_reg_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      ps_q     <= ps_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      pend_q   <= pend_d;
      rd_hit_q <= rd_hit_d;
      rd_reg_q <= rd_reg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dma_io_rdata = io_chain_rdata(rd_hit_q, rd_reg_q, dma_io_rdata_in);
  assign timer_irq    = pend_q && ctrl_q[CTRL_IE];

endmodule
